period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchronizer flops on pulse_in, minimum 2.
REQ-002 Parameter EDGE_W, default 16, width of the edge_cnt output.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 res  input  1  reset; synchronous, active-high.
REQ-005 pulse_in  input  1  step/clock pulse to be measured; may be asynchronous to clk.
REQ-006 max_cnt  input  32  timeout limit in clk cycles; 0 disables the timeout.
REQ-007 period  output  32  last measured period in clk cycles, rising edge to rising edge.
REQ-008 valid  output  1  one-cycle strobe; high when period has just been updated.
REQ-009 stall  output  1  level; high when no edge has arrived within max_cnt cycles.
REQ-010 edge_cnt  output  EDGE_W  running count of detected rising edges; wraps modulo 2^EDGE_W.

Function
REQ-011 pulse_in SHALL pass through SYNC_STAGES flops, plus one history flop; a detected edge (det) = last sync stage high and history flop low.
REQ-012 The FSM SHALL have two states: IDLE (waiting for first edge) and MEAS (counting between edges).
REQ-013 A 32-bit counter cnt SHALL clear to 0 on every det and otherwise increment by 1 each clock while in MEAS.
REQ-014 IDLE + det -> MEAS, cnt <= 0; no valid pulse, period unchanged.
REQ-015 MEAS + det -> stay MEAS: period <= cnt + 1, valid <= 1 for exactly one cycle, stall <= 0, cnt <= 0.
REQ-016 MEAS with no det, max_cnt != 0, cnt + 1 == max_cnt -> IDLE: stall <= 1, period unchanged, no valid.
REQ-017 det and timeout in the same cycle: det wins (REQ-015 applies, no stall).
REQ-018 max_cnt == 0: no timeout; cnt saturates at 32'hFFFF_FFFF and holds until the next det.
REQ-019 A period measured while cnt is saturated SHALL report 32'hFFFF_FFFF (no wrap).
REQ-020 edge_cnt SHALL increment by 1 on every det in any state, wrapping from all-ones to 0.
REQ-021 Latency: valid SHALL rise on the clock edge SYNC_STAGES cycles after the clk edge that first samples pulse_in high.
REQ-022 Minimum measurable period is 2 (pulse_in toggling every clk cycle); glitches shorter than one clk are not guaranteed to be detected.
REQ-023 stall SHALL remain high until the next valid measurement clears it; a single edge from IDLE does not clear it.
REQ-024 max_cnt SHALL be sampled live each cycle; a change during MEAS applies immediately to the comparison.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 With res high at a clk edge: state <= IDLE, cnt <= 0, period <= 0, valid <= 0, stall <= 0, edge_cnt <= 0, all sync and history flops <= 0.
REQ-027 res asserted mid-measurement SHALL discard the partial count; the first edge after release only arms MEAS (no valid).
REQ-028 res SHALL dominate det, timeout and all other conditions in the same cycle.

Verification
REQ-029 Reset, then pulse_in square wave of period 10 clk, max_cnt=0 -> first edge: no valid; every later edge: valid one cycle, period=10; edge_cnt increments by 1 per edge.
REQ-030 Period-10 train, then pulse_in held low, max_cnt=20 -> stall rises 20 clk after the last det, state IDLE, period still 10; restart train -> stall clears at the second new edge with period=10.
REQ-031 pulse_in toggling every clk cycle -> valid every 2 cycles, period=2; pulse aligned with clk edge -> valid exactly 2 clk later (SYNC_STAGES=2).
REQ-032 Assert res for one cycle 5 clk into a period-10 measurement -> all outputs 0; next edge gives no valid; following edge gives period=10.
REQ-033 Set max_cnt=10 with edges exactly 10 clk apart -> det coincides with timeout; valid pulses, period=10, stall stays 0.
REQ-034 Force edge_cnt to all-ones (EDGE_W=4: 15 edges) then one more edge -> edge_cnt=0.

Source files
------------

// File: rtl/period_meter.sv
// Period meter: synchronizes pulse_in, detects rising edges and reports the
// edge-to-edge period in clk cycles, with an optional no-edge timeout (stall).
module period_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_W      = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              pulse_in,
  input  logic [31:0]       max_cnt,
  output logic [31:0]       period,
  output logic              valid,
  output logic              stall,
  output logic [EDGE_W-1:0] edge_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [EDGE_W-1:0] EDGE_ONE = {{(EDGE_W-1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic [31:0]            cnt_r;

  logic        det_s;
  logic        cnt_sat_s;
  logic        timeout_s;
  logic [31:0] cnt_inc_s;
  logic [31:0] meas_val_s;

  // Edge detect and next-count / timeout decode from current state
  always_comb begin
    det_s      = sync_r[SYNC_STAGES-1] & ~hist_r;
    cnt_inc_s  = cnt_r + 32'd1;
    cnt_sat_s  = (cnt_r == 32'hFFFF_FFFF);
    timeout_s  = (max_cnt != 32'd0) && (cnt_inc_s == max_cnt);
    // A saturated counter reports all-ones rather than wrapping to zero.
    meas_val_s = cnt_sat_s ? 32'hFFFF_FFFF : cnt_inc_s;
  end

  // Synchronizer, measurement FSM, counter and registered outputs
  always_ff @(posedge clk) begin
    if (res) begin
      state_r  <= IDLE;
      sync_r   <= {SYNC_STAGES{1'b0}};
      hist_r   <= 1'b0;
      cnt_r    <= 32'd0;
      period   <= 32'd0;
      valid    <= 1'b0;
      stall    <= 1'b0;
      edge_cnt <= {EDGE_W{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pulse_in};
      hist_r <= sync_r[SYNC_STAGES-1];
      valid  <= 1'b0;

      if (det_s) begin
        edge_cnt <= edge_cnt + EDGE_ONE;
      end else begin
        edge_cnt <= edge_cnt;
      end

      case (state_r)
        IDLE: begin
          cnt_r <= 32'd0;
          if (det_s) begin
            state_r <= MEAS;
          end else begin
            state_r <= IDLE;
          end
        end
        MEAS: begin
          // An edge landing on the timeout cycle still counts as a measurement.
          if (det_s) begin
            period  <= meas_val_s;
            valid   <= 1'b1;
            stall   <= 1'b0;
            cnt_r   <= 32'd0;
            state_r <= MEAS;
          end else if (timeout_s) begin
            stall   <= 1'b1;
            cnt_r   <= 32'd0;
            state_r <= IDLE;
          end else if (!cnt_sat_s) begin
            cnt_r   <= cnt_inc_s;
            state_r <= MEAS;
          end else begin
            cnt_r   <= cnt_r;
            state_r <= MEAS;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: timestamp-based reference model checked
// every cycle, directed scenarios with literal expectations, then random pulses.
module tb_period_meter;

  localparam int S  = 2;
  localparam int EW = 4;
  localparam int HIST_N = 32768;

  logic          clk;
  logic          res;
  logic          pulse_in;
  logic [31:0]   max_cnt;
  logic [31:0]   period;
  logic          valid;
  logic          stall;
  logic [EW-1:0] edge_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  period_meter #(.SYNC_STAGES(S), .EDGE_W(EW)) dut (
    .clk      (clk),
    .res      (res),
    .pulse_in (pulse_in),
    .max_cnt  (max_cnt),
    .period   (period),
    .valid    (valid),
    .stall    (stall),
    .edge_cnt (edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pulse samples per clock edge, edges as timestamps.
  bit            p_hist [0:HIST_N-1];
  int            last_reset = 0;
  int            last_det   = 0;
  bit            armed      = 1'b0;
  bit            started    = 1'b0;
  logic [31:0]   m_period   = 32'd0;
  bit            m_valid    = 1'b0;
  bit            m_stall    = 1'b0;
  logic [EW-1:0] m_ecnt     = '0;

  function automatic bit pe(input int k);
    if (k <= last_reset || k >= HIST_N) return 1'b0;
    return p_hist[k];
  endfunction

  initial begin
    bit     det;
    longint el;
    forever begin
      @(posedge clk);
      cyc++;
      if (res) begin
        started    = 1'b1;
        last_reset = cyc;
        armed      = 1'b0;
        m_period   = 32'd0;
        m_valid    = 1'b0;
        m_stall    = 1'b0;
        m_ecnt     = '0;
      end else begin
        if (cyc < HIST_N) p_hist[cyc] = pulse_in;
        det     = pe(cyc - S) && !pe(cyc - S - 1);
        m_valid = 1'b0;
        el      = longint'(cyc) - longint'(last_det);
        if (det) begin
          m_ecnt = m_ecnt + 4'd1;
          if (armed) begin
            m_period = (el > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : el[31:0];
            m_valid  = 1'b1;
            m_stall  = 1'b0;
          end
          armed    = 1'b1;
          last_det = cyc;
        end else if (armed && max_cnt != 32'd0 && el == longint'(max_cnt)) begin
          armed   = 1'b0;
          m_stall = 1'b1;
        end
      end
      #1;
      if (started) begin
        chk("period",   period,           m_period);
        chk("valid",    {31'd0, valid},   {31'd0, m_valid});
        chk("stall",    {31'd0, stall},   {31'd0, m_stall});
        chk("edge_cnt", {28'd0, edge_cnt}, {28'd0, m_ecnt});
      end
    end
  end

  task automatic drive(input logic level, input int cycles);
    pulse_in = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic train(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, half);
      drive(1'b0, half);
    end
  endtask

  task automatic do_reset(input int cycles);
    res = 1'b1;
    pulse_in = 1'b0;
    repeat (cycles) @(negedge clk);
    res = 1'b0;
  endtask

  initial begin
    res      = 1'b1;
    pulse_in = 1'b0;
    max_cnt  = 32'd0;
    @(negedge clk);
    do_reset(3);
    chk("rst_period", period, 32'd0);
    chk("rst_valid",  {31'd0, valid}, 32'd0);
    chk("rst_stall",  {31'd0, stall}, 32'd0);
    chk("rst_edges",  {28'd0, edge_cnt}, 32'd0);

    // Period-10 train, no timeout: six edges, five measurements of 10.
    train(5, 6);
    chk("p10_period", period, 32'd10);
    chk("p10_edges",  {28'd0, edge_cnt}, 32'd6);

    // Timeout after 20 idle cycles, then restart clears stall on the second edge.
    max_cnt = 32'd20;
    drive(1'b0, 30);
    chk("to_stall",  {31'd0, stall}, 32'd1);
    chk("to_period", period, 32'd10);
    drive(1'b1, 5);
    drive(1'b0, 5);
    chk("rearm_stall", {31'd0, stall}, 32'd1);
    train(5, 2);
    chk("restart_stall",  {31'd0, stall}, 32'd0);
    chk("restart_period", period, 32'd10);

    // Fastest input: toggling every clock.
    max_cnt = 32'd0;
    train(1, 12);
    chk("fast_period", period, 32'd2);

    // Edge coincides with timeout: edge wins.
    max_cnt = 32'd10;
    train(5, 4);
    chk("coinc_stall",  {31'd0, stall}, 32'd0);
    chk("coinc_period", period, 32'd10);

    // Reset five cycles into a measurement discards it.
    max_cnt = 32'd0;
    train(5, 2);
    drive(1'b1, 5);
    res = 1'b1;
    drive(1'b0, 1);
    res = 1'b0;
    chk("mid_rst_period", period, 32'd0);
    chk("mid_rst_edges",  {28'd0, edge_cnt}, 32'd0);
    drive(1'b0, 4);
    drive(1'b1, 5);
    drive(1'b0, 5);
    chk("mid_rst_first", period, 32'd0);
    train(5, 2);
    chk("mid_rst_period10", period, 32'd10);
    chk("mid_rst_edges3",   {28'd0, edge_cnt}, 32'd3);

    // Random pulse trains with live max_cnt changes and occasional resets.
    for (int seg = 0; seg < 220; seg++) begin
      if ($urandom_range(0, 9) == 0)
        max_cnt = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
      if ($urandom_range(0, 39) == 0) begin
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
      end
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 15));
    end

    // Edge counter wrap with a 4-bit counter: sixteen edges return it to zero.
    do_reset(2);
    max_cnt = 32'd0;
    train(2, 16);
    drive(1'b0, 6);
    chk("wrap_edges",  {28'd0, edge_cnt}, 32'd0);
    chk("wrap_period", period, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
